busy_table: RTL

BUSY_TABLE -- requirements
Module: busy_table

---
 rtl/busy_table_pkg.sv | 31 +++
 rtl/busy_table.sv | 134 +++++++++++++
 2 files changed

// File: rtl/busy_table_pkg.sv
// Shared pipeline types for the rename / issue / writeback / commit stages.
// The bundle types here are common to every stage that touches physical
// register numbers. The busy table only reads them.
package busy_table_pkg;

    // Width of a physical register address field in every bundle.
    localparam int PREG_ADDR_W    = 16;
    // Width of the op identifier. Its top bit is the lane valid flag.
    localparam int OPID_W         = 16;
    localparam int OPID_VALID_BIT = 15;

    // One renamed op: two source physical registers and one destination.
    typedef struct packed {
        logic [OPID_W-1:0]                opid;
        logic [1:0][PREG_ADDR_W-1:0]      prsa;
        logic [PREG_ADDR_W-1:0]           prda;
    } ren_bundle_t;

    // One execute writeback: the physical register whose value is now ready.
    typedef struct packed {
        logic [OPID_W-1:0]                opid;
        logic [PREG_ADDR_W-1:0]           prda;
    } exe_bundle_t;

    // One commit lane. A redirect on lane 0 flushes all speculative state.
    typedef struct packed {
        logic [OPID_W-1:0]                opid;
        logic                             redir;
    } com_bundle_t;

endpackage

// File: rtl/busy_table.sv
// Physical register busy table.
// This is a flat bitmap with one bit per physical register. An accepted rename
// marks its destination busy. A writeback marks it free. A commit redirect
// clears the whole table. busy_resp answers source queries in the same cycle
// and takes earlier lanes of the same rename bundle into account.
// Optional feature: define BUSY_WB_BYPASS_EN to let a same-cycle writeback
// read as not busy. Without it, busy_resp reflects only the stored bitmap
// plus the intra-bundle forwarding.
module busy_table
    import busy_table_pkg::*;
#(
    parameter int rwd   = 4,
    parameter int ewd   = 4,
    parameter int cwd   = 4,
    parameter int prnum = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  ren_bundle_t [rwd-1:0]   ren_bundle,
    input  logic [rwd-1:0]          ready,
    input  exe_bundle_t [ewd-1:0]   exe_bundle,
    input  com_bundle_t [cwd-1:0]   com_bundle,
    output logic [rwd-1:0][1:0]     busy_resp
);

    // Index width into the bitmap. Higher address bits alias onto it.
    localparam int AW = (prnum > 1) ? $clog2(prnum) : 1;

    // Bitmap index of a physical register address.
    function automatic logic [AW-1:0] preg_idx(input logic [PREG_ADDR_W-1:0] a);
        return a[AW-1:0];
    endfunction

    // Two addresses select the same busy bit.
    function automatic logic preg_match(input logic [PREG_ADDR_W-1:0] a,
                                        input logic [PREG_ADDR_W-1:0] b);
        return (a[AW-1:0] == b[AW-1:0]);
    endfunction

    // The address is not the hardwired never-busy register 0.
    function automatic logic preg_nonzero(input logic [PREG_ADDR_W-1:0] a);
        return (a[AW-1:0] != {AW{1'b0}});
    endfunction

    logic [prnum-1:0] busy_r;
    logic [prnum-1:0] busy_nxt_s;
    logic [prnum-1:0] set_mask_s;
    logic [prnum-1:0] clr_mask_s;
    logic             redir_s;
    logic             resp_bit_s;
    logic             unused_s;

    assign redir_s = com_bundle[0].redir;

    // Only some bundle fields feed the table. Fold the whole bundles here so
    // the remaining bits are visibly intentional.
    assign unused_s = ^{ren_bundle, exe_bundle, com_bundle};

    // Destinations of accepted rename lanes. Register 0 is never marked busy.
    always_comb begin
        set_mask_s = '0;
        for (int i = 0; i < rwd; i++) begin
            set_mask_s[preg_idx(ren_bundle[i].prda)] =
                set_mask_s[preg_idx(ren_bundle[i].prda)] |
                (ren_bundle[i].opid[OPID_VALID_BIT] & ready[i] &
                 preg_nonzero(ren_bundle[i].prda));
        end
    end

    // Registers produced by valid writeback lanes this cycle.
    always_comb begin
        clr_mask_s = '0;
        for (int e = 0; e < ewd; e++) begin
            clr_mask_s[preg_idx(exe_bundle[e].prda)] =
                clr_mask_s[preg_idx(exe_bundle[e].prda)] |
                exe_bundle[e].opid[OPID_VALID_BIT];
        end
    end

    // Next bitmap. A set beats a clear on the same register. A redirect
    // discards both and empties the table.
    always_comb begin
        busy_nxt_s = busy_r;
        if (redir_s) begin
            busy_nxt_s = '0;
        end else begin
            busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
            busy_nxt_s[0] = 1'b0;
        end
    end

    // Bitmap storage. Reset empties it at once, independent of the clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Source busy lookup. The steps are applied in order: stored bit, then
    // writeback bypass, then forcing by an older valid lane of the same
    // bundle that writes this source. The forcing uses only the valid bit and
    // ignores ready, because issue accepts lanes in order.
    always_comb begin
        busy_resp  = '0;
        resp_bit_s = 1'b0;
        for (int i = 0; i < rwd; i++) begin
            for (int k = 0; k < 2; k++) begin
                resp_bit_s = busy_r[preg_idx(ren_bundle[i].prsa[k])] &
                             preg_nonzero(ren_bundle[i].prsa[k]);
`ifdef BUSY_WB_BYPASS_EN
                for (int e = 0; e < ewd; e++) begin
                    resp_bit_s = resp_bit_s &
                        ~(exe_bundle[e].opid[OPID_VALID_BIT] &
                          preg_match(exe_bundle[e].prda, ren_bundle[i].prsa[k]));
                end
`else
                resp_bit_s = resp_bit_s;
`endif
                for (int j = 0; j < rwd; j++) begin
                    resp_bit_s = resp_bit_s |
                        ((j < i) &
                         ren_bundle[j].opid[OPID_VALID_BIT] &
                         preg_match(ren_bundle[j].prda, ren_bundle[i].prsa[k]) &
                         preg_nonzero(ren_bundle[j].prda));
                end
                busy_resp[i][k] = rst & ren_bundle[i].opid[OPID_VALID_BIT] &
                                  resp_bit_s;
            end
        end
    end

endmodule
